regfile_mp: RTL

// - Parametrised multi-port register file for the 8-bit CPU datapath, replacing the fixed 8x8, 2-read/1-write file.
// - Adds the following:
//   - configurable read-port count
//   - two write ports with a fixed priority
//   - optional write-to-read bypass
//   - optional hardwired-zero register
//   - per-register pending scoreboard for multi-cycle producers
//   - post-reset clear sweep
// - Sits between decode (read ports, reservations) and writeback (write ports).

---
 rtl/regfile_mp.sv | 66 ++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, pending scoreboard and post-reset clear sweep
module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     init_done
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending, clr_mask, set_mask;
  logic w0, w1, rv;
  assign w0 = init_done && we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign w1 = init_done && we1 && !(ZERO_REG != 0 && wa1 == '0);
  assign rv = init_done && rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
  assign clr_mask = (DEPTH'(w0) << wa0) | (DEPTH'(w1) << wa1);
  assign set_mask = DEPTH'(rv) << rsv_addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      init_done <= 1'b0;
      pending   <= '0;
    end else if (state == CLEAR) begin
      regs[clr_ptr] <= '0;
      if (clr_ptr == '1) begin
        state     <= READY;
        init_done <= 1'b1;
      end else begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end else begin
      if (w0) regs[wa0] <= wd0;
      if (w1) regs[wa1] <= wd1;
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic hit0, hit1, zero;
    assign a    = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit0 = BYPASS != 0 && w0 && wa0 == a;
    assign hit1 = BYPASS != 0 && w1 && wa1 == a;
    assign zero = !init_done || (ZERO_REG != 0 && a == '0);
    assign rd_data[i*DATA_W +: DATA_W] = zero ? '0 : hit1 ? wd1 : hit0 ? wd0 : regs[a];
    assign rd_busy[i] = (zero || hit0 || hit1) ? 1'b0 : pending[a];
  end
endmodule
